// File: rtl/accum51_sequencer.sv
// Accumulation controller: loads a 51-bit base, then adds up to MAX_TERMS 29-bit addends
// through one customAdder51_22 under a valid/ready handshake, returning sum plus sticky carry.

module customAdder51_22 (
  input  logic [50:0] a_i,
  input  logic [28:0] b_i,
  output logic [51:0] sum_o
);
  assign sum_o = {1'b0, a_i} + {23'b0, b_i};
endmodule

module accum51_sequencer #(
  parameter int unsigned MAX_TERMS = 16,
  parameter int unsigned CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [50:0]      base,
  input  logic [CNT_W-1:0] num_terms,
  input  logic             term_valid,
  input  logic [28:0]      term_data,
  output logic             term_ready,
  input  logic             abort,
  output logic             busy,
  output logic             result_valid,
  output logic [50:0]      result,
  output logic             overflow,
  input  logic             result_ack
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e           state_q, state_d;
  logic [50:0]      acc_q, acc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             ovf_q, ovf_d;
  logic             term_ready_q, busy_q, result_valid_q;
  logic [CNT_W-1:0] clamped;
  logic [51:0]      sum;

  customAdder51_22 u_adder (
    .a_i   (acc_q),
    .b_i   (term_data),
    .sum_o (sum)
  );

  assign clamped = (num_terms > CNT_W'(MAX_TERMS)) ? CNT_W'(MAX_TERMS) : num_terms;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = base;
          rem_d   = clamped;
          ovf_d   = 1'b0;
          state_d = (clamped == '0) ? StDone : StAccum;
        end
      end
      StAccum: begin
        // Abort wins over a simultaneous transfer; that term is dropped.
        if (abort) begin
          state_d = StIdle;
        end else if (term_valid) begin
          acc_d = sum[50:0];
          ovf_d = ovf_q | sum[51];
          rem_d = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) state_d = StDone;
        end
      end
      StDone: begin
        if (abort || result_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs are registered from the next state so they carry no input paths.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      acc_q          <= '0;
      rem_q          <= '0;
      ovf_q          <= 1'b0;
      term_ready_q   <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      rem_q          <= rem_d;
      ovf_q          <= ovf_d;
      term_ready_q   <= (state_d == StAccum);
      busy_q         <= (state_d != StIdle);
      result_valid_q <= (state_d == StDone);
    end
  end

  assign term_ready   = term_ready_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign result       = acc_q;
  assign overflow     = ovf_q;

endmodule
